// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory-access stage: load/store op codes, FSM states, word constants.
// Op-class helpers keep the top and the lane-alignment logic in agreement.
package mem_lsu_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic mem_is_load(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic mem_is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: big-endian byte enables, replicated store data, extended load data, misalign flag.
// Zero latency; no flow control of its own.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  memop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic        is_mem_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [3:0]  sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte    = ld_data_i[7:0];
    ld_half    = addr_lo_i[1] ? ld_data_i[15:0] : ld_data_i[31:16];
    is_load_o  = mem_is_load(memop_i);
    is_mem_o   = mem_is_load(memop_i) | mem_is_store(memop_i);
    misalign_o = 1'b0;
    sel_o      = 4'b0000;
    st_data_o  = st_data_i;
    ld_data_o  = ld_data_i;

    // Byte offset 0 sits in the most significant lane.
    case (addr_lo_i)
      2'd0:    ld_byte = ld_data_i[31:24];
      2'd1:    ld_byte = ld_data_i[23:16];
      2'd2:    ld_byte = ld_data_i[15:8];
      default: ld_byte = ld_data_i[7:0];
    endcase

    case (memop_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        sel_o     = 4'b1000 >> addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = (memop_i == MEM_LB) ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        misalign_o = addr_lo_i[0];
        sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        st_data_o  = {2{st_data_i[15:0]}};
        ld_data_o  = (memop_i == MEM_LH) ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      end
      MEM_LW, MEM_SW: begin
        misalign_o = |addr_lo_i;
        sel_o      = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// EX/MEM register plus one data-bus transaction per load/store; latency 1 for non-memory ops, ack+1 for memory ops.
// Backpressure: stallreq_o holds upstream from issue until the ack (or timeout) cycle.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stallreq_o,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        excp_ale_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic          valid_q, valid_d;
  logic [4:0]    wd_q, wd_d;
  logic          wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ale_q, ale_d;
  logic          err_q, err_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    lo_q, lo_d;
  logic          pwreg_q, pwreg_d;
  logic          flushed_q, flushed_d;

  logic          in_wait;
  logic          tmo_hit;
  logic [3:0]    al_op;
  logic [1:0]    al_lo;
  logic          a_is_mem, a_is_load, a_misalign;
  logic [3:0]    a_sel;
  logic [31:0]   a_st_data, a_ld_data;

  // While waiting, the aligner works on the captured op so the load result can be extended at ack.
  assign in_wait = (state_q == S_WAIT);
  assign al_op   = in_wait ? op_q : memop_i;
  assign al_lo   = in_wait ? lo_q : mem_addr_i[1:0];
  assign tmo_hit = (TIMEOUT_CYC > 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  lsu_align u_align (
    .memop_i    (al_op),
    .addr_lo_i  (al_lo),
    .st_data_i  (mem_data_i),
    .ld_data_i  (bus_rdata_i),
    .is_mem_o   (a_is_mem),
    .is_load_o  (a_is_load),
    .misalign_o (a_misalign),
    .sel_o      (a_sel),
    .st_data_o  (a_st_data),
    .ld_data_o  (a_ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    bwdata_d   = bwdata_q;
    valid_d    = valid_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    ale_d      = ale_q;
    err_d      = err_q;
    op_d       = op_q;
    lo_d       = lo_q;
    pwreg_d    = pwreg_q;
    flushed_d  = flushed_q;
    stallreq_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        wreg_d  = 1'b0;
        ale_d   = 1'b0;
        err_d   = 1'b0;
        if (valid_i && !flush_i) begin
          wd_d = wd_i;
          if (!a_is_mem) begin
            valid_d = 1'b1;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
          end else if (a_misalign) begin
            valid_d = 1'b1;
            ale_d   = 1'b1;
            wdata_d = wdata_i;
          end else begin
            stallreq_o = 1'b1;
            req_d      = 1'b1;
            we_d       = mem_is_store(memop_i);
            addr_d     = {mem_addr_i[31:2], 2'b00};
            sel_d      = a_sel;
            bwdata_d   = a_st_data;
            op_d       = memop_i;
            lo_d       = mem_addr_i[1:0];
            pwreg_d    = wreg_i & a_is_load;
            flushed_d  = 1'b0;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        ale_d     = 1'b0;
        err_d     = 1'b0;
        flushed_d = flushed_q | flush_i;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack_i) begin
          req_d   = 1'b0;
          valid_d = !flushed_d;
          wreg_d  = pwreg_q & !flushed_d;
          if (a_is_load) begin
            wdata_d = a_ld_data;
          end
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          valid_d = !flushed_d;
          wreg_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= ZERO_WORD;
      sel_q     <= 4'b0000;
      bwdata_q  <= ZERO_WORD;
      valid_q   <= 1'b0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      wdata_q   <= ZERO_WORD;
      ale_q     <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= MEM_NOP;
      lo_q      <= 2'b00;
      pwreg_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      bwdata_q  <= bwdata_d;
      valid_q   <= valid_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      ale_q     <= ale_d;
      err_q     <= err_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      pwreg_q   <= pwreg_d;
      flushed_q <= flushed_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = bwdata_q;
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign excp_ale_o  = ale_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: byte-lane model computes expected bus requests and results,
// a negedge monitor compares every cycle, and literal values pin the headline cases.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        valid_i, flush_i, wreg_i, bus_ack_i;
  logic [3:0]  memop_i;
  logic [31:0] mem_addr_i, mem_data_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        bus_req_o, bus_we_o, stallreq_o, valid_o, wreg_o, excp_ale_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o;

  mem_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .memop_i(memop_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .stallreq_o(stallreq_o),
    .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .excp_ale_o(excp_ale_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; } bus_t;
  typedef struct { logic [4:0] wd; logic wreg; logic [31:0] wdata; logic chk_data; logic ale; logic err; } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: access size in bytes, 0 for non-memory ops.
  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic logic m_sel(input int size, input int lo, input int lane);
    return (lane >= lo) && (lane < lo + size);
  endfunction

  function automatic logic [3:0] m_sel4(input int size, input int lo);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++) s[3-i] = m_sel(size, lo, i);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = 8'(d >> (8 * (size - 1 - (i % size))));
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int size, input int lo, input bit sgn, input logic [31:0] rd);
    logic [31:0] v = 32'h0;
    for (int j = 0; j < size; j++) v = (v << 8) | 32'(rd[31-8*(lo+j) -: 8]);
    if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  // Per-cycle monitor of the registered outputs.
  bus_t cur_bus;
  logic have_cur = 1'b0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      req_prev = 1'b0;
    end else begin
      if (bus_req_o && !req_prev) begin
        if (exp_bus.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected_bus_req", 32'(bus_req_o), 32'd0);
        end else begin
          cur_bus  = exp_bus.pop_front();
          have_cur = 1'b1;
        end
      end
      if (bus_req_o && have_cur) begin
        check("bus_we", 32'(bus_we_o), 32'(cur_bus.we));
        check("bus_addr", bus_addr_o, cur_bus.addr);
        check("bus_sel", 32'(bus_sel_o), 32'(cur_bus.sel));
        if (cur_bus.we) check("bus_wdata", bus_wdata_o, cur_bus.wdata);
      end
      req_prev = bus_req_o;
      if (valid_o) begin
        if (exp_res.size() == 0) begin
          check("unexpected_valid", 32'(valid_o), 32'd0);
        end else begin
          r = exp_res.pop_front();
          check("res_wd", 32'(wd_o), 32'(r.wd));
          check("res_wreg", 32'(wreg_o), 32'(r.wreg));
          check("res_ale", 32'(excp_ale_o), 32'(r.ale));
          check("res_err", 32'(bus_err_o), 32'(r.err));
          if (r.chk_data) check("res_wdata", wdata_o, r.wdata);
        end
      end else begin
        check("idle_ale", 32'(excp_ale_o), 32'd0);
        check("idle_err", 32'(bus_err_o), 32'd0);
      end
    end
  end

  // One instruction from EX; ack_cyc = WAIT cycle carrying the ack (0 = never, lets the timeout fire).
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ack_cyc, input bit flush_wait,
                       output int stalls, output logic [3:0] sel_seen,
                       output logic [31:0] bwd_seen, output logic we_seen);
    int   size = op_size(op);
    int   lo   = int'(addr[1:0]);
    bit   st   = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    bit   mis  = (size > 1) && ((lo % size) != 0);
    bit   acc  = (size > 0) && !mis;
    bit   done = 1'b0;
    bus_t b;
    res_t r;
    stalls = 0; sel_seen = 4'h0; bwd_seen = 32'h0; we_seen = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b0; memop_i = op; mem_addr_i = addr; mem_data_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    bus_ack_i = (size == 0);           // a stray ack outside WAIT must be ignored
    bus_rdata_i = 32'hDEAD_BEEF;
    r.wd = wd; r.wreg = 1'b0; r.wdata = wdata; r.chk_data = 1'b0; r.ale = 1'b0; r.err = 1'b0;
    if (size == 0) begin
      r.wreg = wreg; r.chk_data = 1'b1;
      exp_res.push_back(r);
    end else if (mis) begin
      r.ale = 1'b1;
      exp_res.push_back(r);
    end else begin
      b.we = st; b.addr = {addr[31:2], 2'b00}; b.sel = m_sel4(size, lo); b.wdata = m_wdata(size, sdata);
      exp_bus.push_back(b);
      if (!flush_wait) begin
        if (ack_cyc != 0) begin
          r.wreg = wreg && !st; r.chk_data = !st;
          r.wdata = m_load(size, lo, (op == MEM_LB) || (op == MEM_LH), rdata);
        end else begin
          r.err = 1'b1;
        end
        exp_res.push_back(r);
      end
    end
    #1;
    check("stall_issue", 32'(stallreq_o), 32'(acc));
    if (stallreq_o) stalls++;
    if (acc) begin
      for (int k = 1; k <= TMO + 2 && !done; k++) begin
        @(negedge clk);
        bus_ack_i   = (k == ack_cyc);
        bus_rdata_i = (k == ack_cyc) ? rdata : 32'h0BAD_0BAD;
        flush_i     = flush_wait && (k == 1);
        #1;
        check("req_held", 32'(bus_req_o), 32'd1);
        if (k == 1) begin
          sel_seen = bus_sel_o; bwd_seen = bus_wdata_o; we_seen = bus_we_o;
        end
        done = (k == ack_cyc) || (k == TMO);
        check("stall_wait", 32'(stallreq_o), 32'(!done));
        if (stallreq_o) stalls++;
      end
      if (!done) check("ack_or_timeout_reached", 32'(done), 32'd1);
    end
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; memop_i = MEM_NOP;
    #1;
  endtask

  int          st_n;
  logic [3:0]  sel_s;
  logic [31:0] bwd_s;
  logic        we_s;

  initial begin
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; memop_i = MEM_NOP; mem_addr_i = 32'h0;
    mem_data_i = 32'h0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; bus_ack_i = 1'b0;
    bus_rdata_i = 32'h0;
    #12;
    check("rst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o[7:0]}, 32'd0);
    check("rst_bus_wdata", bus_wdata_o, 32'd0);
    check("rst_res", {valid_o, wd_o, wreg_o, excp_ale_o, bus_err_o, stallreq_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    @(negedge clk); rst = 1'b1;

    do_op(MEM_NOP, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFE_0001, 32'h0, 0, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("nop_valid", 32'(valid_o), 32'd1);
    check("nop_wdata", wdata_o, 32'hCAFE_0001);

    do_op(MEM_LW, 32'h100, 32'h0, 5'd5, 1'b1, 32'h0, 32'h1234_5678, 3, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lw_sel", 32'(sel_s), 32'h0000_000F);
    check("lw_stalls", st_n, 32'd3);
    check("lw_wdata", wdata_o, 32'h1234_5678);
    check("lw_wreg", 32'(wreg_o), 32'd1);

    do_op(MEM_LB, 32'h103, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0000_00F0, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lb_sel", 32'(sel_s), 32'h0000_0001);
    check("lb_wdata", wdata_o, 32'hFFFF_FFF0);

    // Ack in the same cycle the timeout would fire: the ack must win.
    do_op(MEM_LBU, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0000_00F0, TMO, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lbu_wdata", wdata_o, 32'h0000_00F0);
    check("lbu_no_err", 32'(bus_err_o), 32'd0);

    do_op(MEM_SH, 32'h202, 32'hAAAA_BEEF, 5'd8, 1'b1, 32'h0, 32'h0, 2, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("sh_we", 32'(we_s), 32'd1);
    check("sh_sel", 32'(sel_s), 32'h0000_0003);
    check("sh_bus_wdata", bwd_s, 32'hBEEF_BEEF);
    check("sh_wreg", 32'(wreg_o), 32'd0);

    do_op(MEM_LW, 32'h101, 32'h0, 5'd9, 1'b1, 32'h5555_5555, 32'h0, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("ale_pulse", 32'(excp_ale_o), 32'd1);
    check("ale_wreg", 32'(wreg_o), 32'd0);
    check("ale_no_req", 32'(bus_req_o), 32'd0);

    do_op(MEM_LH, 32'h106, 32'h0, 5'd10, 1'b1, 32'h0, 32'h1234_8001, 2, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lh_wdata", wdata_o, 32'hFFFF_8001);
    do_op(MEM_LHU, 32'h104, 32'h0, 5'd11, 1'b1, 32'h0, 32'h9ABC_0000, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lhu_wdata", wdata_o, 32'h0000_9ABC);
    do_op(MEM_SB, 32'h301, 32'h0000_00A5, 5'd12, 1'b1, 32'h0, 32'h0, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("sb_sel", 32'(sel_s), 32'h0000_0004);
    check("sb_bus_wdata", bwd_s, 32'hA5A5_A5A5);
    do_op(MEM_SW, 32'h304, 32'h1122_3344, 5'd13, 1'b0, 32'h0, 32'h0, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    do_op(MEM_LH, 32'h103, 32'h0, 5'd14, 1'b1, 32'h0, 32'h0, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("lh_ale", 32'(excp_ale_o), 32'd1);

    do_op(MEM_LW, 32'h300, 32'h0, 5'd15, 1'b1, 32'h0, 32'h7777_7777, 3, 1'b1, st_n, sel_s, bwd_s, we_s);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_stalls", st_n, 32'd3);

    do_op(MEM_LW, 32'h400, 32'h0, 5'd16, 1'b1, 32'h0, 32'h0, 0, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("tmo_err", 32'(bus_err_o), 32'd1);
    check("tmo_valid_wreg", {valid_o, wreg_o}, 32'd2);
    check("tmo_stalls", st_n, 32'd4);
    check("tmo_req_dropped", 32'(bus_req_o), 32'd0);

    // Flushed instruction in IDLE never reaches the bus.
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; memop_i = MEM_LW; mem_addr_i = 32'h600;
    #1 check("idle_flush_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0; memop_i = MEM_NOP;
    #1 check("idle_flush_valid", 32'(valid_o), 32'd0);

    // Reset while a transaction is outstanding drops the request without a clock.
    exp_bus.push_back('{1'b0, 32'h500, 4'b1111, 32'h0});
    @(negedge clk);
    valid_i = 1'b1; memop_i = MEM_LW; mem_addr_i = 32'h500; wd_i = 5'd17; wreg_i = 1'b1;
    @(negedge clk);
    #1 check("rst_wait_req_before", 32'(bus_req_o), 32'd1);
    #2 rst = 1'b0;
    #1 check("rst_wait_req_after", 32'(bus_req_o), 32'd0);
    valid_i = 1'b0; memop_i = MEM_NOP;
    @(negedge clk); rst = 1'b1;

    do_op(MEM_LW, 32'h504, 32'h0, 5'd18, 1'b1, 32'h0, 32'hA1B2_C3D4, 1, 1'b0, st_n, sel_s, bwd_s, we_s);
    check("post_rst_wdata", wdata_o, 32'hA1B2_C3D4);

    repeat (3) @(negedge clk);
    #1;
    check("res_queue_drained", exp_res.size(), 32'd0);
    check("bus_queue_drained", exp_bus.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
